// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter that shares one 8-bit add/subtract datapath
// between NREQ requesters, with one operation outstanding at a time.

module sum_cell (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       carry
);
    assign {carry, sum} = {1'b0, a} + {1'b0, b};
endmodule

module minus_cell (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] minus,
    output logic       borrow
);
    assign minus  = a - b;
    assign borrow = (a < b);
endmodule

module alu_share_arb #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_op,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_result,
    output logic              rsp_flag,
    input  logic              rsp_ready
);
    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] op_id_q;
    logic           op_sub_q;
    logic [7:0]     op_a_q;
    logic [7:0]     op_b_q;

    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [7:0]     rsp_result_q;
    logic           rsp_flag_q;

    logic           found;
    logic [IDW-1:0] winner;
    logic           grant;
    int unsigned    idx;

    logic [7:0]     sum;
    logic           carry;
    logic [7:0]     minus;
    logic           borrow;

    // Search ptr+1, ptr+2, ... (mod NREQ); first valid requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
    end

    // Masked during reset so the accept pulse never escapes while state is forced.
    assign grant = (state_q == StIdle) && found && !rst;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (found) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    sum_cell u_sum (
        .a     (op_a_q),
        .b     (op_b_q),
        .sum   (sum),
        .carry (carry)
    );

    minus_cell u_minus (
        .a      (op_a_q),
        .b      (op_b_q),
        .minus  (minus),
        .borrow (borrow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            ptr_q        <= IDW'(NREQ - 1);
            op_id_q      <= '0;
            op_sub_q     <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flag_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && found) begin
                ptr_q    <= winner;
                op_id_q  <= winner;
                op_sub_q <= req_op[winner];
                op_a_q   <= req_a[32'(winner) * 8 +: 8];
                op_b_q   <= req_b[32'(winner) * 8 +: 8];
            end
            if (state_q == StExec) begin
                rsp_valid_q  <= 1'b1;
                rsp_id_q     <= op_id_q;
                rsp_result_q <= op_sub_q ? minus : sum;
                rsp_flag_q   <= op_sub_q ? borrow : carry;
            end
            if (state_q == StResp && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flag   = rsp_flag_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed vectors, multi-cycle corner
// sequences and randomized traffic checked against a transaction-level model.

module tb_alu_share_arb;
    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_op;
    logic [N*8-1:0] req_a;
    logic [N*8-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [7:0]     rsp_result;
    logic           rsp_flag;
    logic           rsp_ready;

    logic [1:0]     b_req_valid;
    logic [1:0]     b_req_op;
    logic [15:0]    b_req_a;
    logic [15:0]    b_req_b;
    logic [1:0]     b_req_ready;
    logic           b_rsp_valid;
    logic [0:0]     b_rsp_id;
    logic [7:0]     b_rsp_result;
    logic           b_rsp_flag;
    logic           b_rsp_ready;

    alu_share_arb #(.NREQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flag   (rsp_flag),
        .rsp_ready  (rsp_ready)
    );

    alu_share_arb #(.NREQ(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (b_req_valid),
        .req_op     (b_req_op),
        .req_a      (b_req_a),
        .req_b      (b_req_b),
        .req_ready  (b_req_ready),
        .rsp_valid  (b_rsp_valid),
        .rsp_id     (b_rsp_id),
        .rsp_result (b_rsp_result),
        .rsp_flag   (b_rsp_flag),
        .rsp_ready  (b_rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state
    int m_ptr;
    bit m_busy;
    bit m_vis;
    int m_cnt;
    int e_id;
    int e_res;
    bit e_flag;
    int last_grant;

    // Values sampled by the most recent step()
    logic [N-1:0] s_ready;
    logic         s_valid;
    logic [1:0]   s_id;
    logic [7:0]   s_res;
    logic         s_flag;

    typedef struct {
        int         id;
        bit         op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        bit         flag;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic void calc(input bit op, input int a, input int b,
                                 output int res, output bit flag);
        if (!op) begin
            res  = (a + b) % 256;
            flag = (a + b) > 255;
        end else begin
            res  = (a - b + 256) % 256;
            flag = a < b;
        end
    endfunction

    task automatic set_req(input int i, input bit v, input bit op,
                           input logic [7:0] a, input logic [7:0] b);
        req_valid[i]     = v;
        req_op[i]        = op;
        req_a[i*8 +: 8]  = a;
        req_b[i*8 +: 8]  = b;
    endtask

    // One clock cycle: sample and check at the falling edge, then advance the model.
    task automatic step();
        int w;
        logic [N-1:0] er;
        @(negedge clk);
        last_grant = -1;
        s_ready = req_ready;
        s_valid = rsp_valid;
        s_id    = rsp_id;
        s_res   = rsp_result;
        s_flag  = rsp_flag;
        if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_result", rsp_result, 0);
            chk("rst_rsp_flag", rsp_flag, 0);
            m_busy = 0;
            m_vis  = 0;
            m_ptr  = N - 1;
        end else begin
            w  = m_busy ? -1 : rr_pick(m_ptr, req_valid);
            er = '0;
            if (w >= 0) er[w] = 1'b1;
            chk("req_ready", req_ready, er);
            chk("rsp_valid", rsp_valid, m_vis);
            if (m_vis) begin
                chk("rsp_id", rsp_id, e_id);
                chk("rsp_result", rsp_result, e_res);
                chk("rsp_flag", rsp_flag, e_flag);
            end
            if (w >= 0) begin
                calc(req_op[w], int'(req_a[w*8 +: 8]), int'(req_b[w*8 +: 8]), e_res, e_flag);
                e_id       = w;
                m_ptr      = w;
                m_busy     = 1;
                m_cnt      = 1;
                last_grant = w;
            end else if (m_vis) begin
                if (rsp_ready) begin
                    m_vis  = 0;
                    m_busy = 0;
                end
            end else if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) m_vis = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit seen;
        set_req(v.id, 1'b1, v.op, v.a, v.b);
        rsp_ready  = 1'b1;
        seen       = 0;
        last_grant = -1;
        for (int t = 0; t < 10 && !seen; t++) begin
            step();
            if (last_grant == v.id) seen = 1;
        end
        chk("vec_grant_seen", seen, 1);
        chk("vec_accept_ready", s_ready, 32'd1 << v.id);
        set_req(v.id, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        chk("vec_exec_not_valid", s_valid, 0);
        step();
        chk("vec_valid", s_valid, 1);
        chk("vec_id", s_id, v.id);
        chk("vec_result", s_res, v.res);
        chk("vec_flag", s_flag, v.flag);
    endtask

    initial begin
        int exp_order [6];
        int ng;
        logic [7:0] h_res;
        logic [1:0] h_id;
        logic h_flag;
        int ng2;
        int nr2;

        rst = 1'b1;
        rsp_ready = 1'b0;
        clear_reqs();
        b_req_valid = '0;
        b_req_op = '0;
        b_req_a = '0;
        b_req_b = '0;
        b_rsp_ready = 1'b0;
        last_grant = -1;
        m_ptr = N - 1;
        m_busy = 0;
        m_vis = 0;
        m_cnt = 0;

        tbl[0] = '{0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0};
        tbl[1] = '{2, 1'b0, 8'hFF, 8'h02, 8'h01, 1'b1};
        tbl[2] = '{1, 1'b1, 8'h03, 8'h05, 8'hFE, 1'b1};
        tbl[3] = '{1, 1'b1, 8'h05, 8'h05, 8'h00, 1'b0};
        tbl[4] = '{3, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1};

        do_reset();
        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // Round-robin with every requester continuously asking.
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, i[0], 8'(16 * i + 3), 8'(i + 1));
        exp_order = '{0, 1, 2, 3, 0, 1};
        ng = 0;
        for (int t = 0; t < 40 && ng < 6; t++) begin
            step();
            if (last_grant >= 0) begin
                chk("rr_order", last_grant, exp_order[ng]);
                ng++;
            end
        end
        chk("rr_count", ng, 6);

        // Backpressure with requests 1 and 3 pending.
        do_reset();
        rsp_ready = 1'b0;
        set_req(1, 1'b1, 1'b0, 8'h11, 8'h22);
        last_grant = -1;
        for (int t = 0; t < 10 && last_grant != 1; t++) step();
        set_req(3, 1'b1, 1'b1, 8'h40, 8'h41);
        s_valid = 1'b0;
        for (int t = 0; t < 10 && !s_valid; t++) step();
        chk("bp_valid", s_valid, 1);
        chk("bp_id", s_id, 1);
        chk("bp_result", s_res, 8'h33);
        h_id = s_id;
        h_res = s_res;
        h_flag = s_flag;
        repeat (5) begin
            step();
            chk("bp_hold_valid", s_valid, 1);
            chk("bp_hold_id", s_id, h_id);
            chk("bp_hold_result", s_res, h_res);
            chk("bp_hold_flag", s_flag, h_flag);
            chk("bp_no_ready", s_ready, 0);
        end
        rsp_ready = 1'b1;
        step();
        step();
        chk("bp_valid_drop", s_valid, 0);
        chk("bp_next_grant", last_grant, 3);

        // Reset during EXEC drops the operation and restores pointer priority.
        do_reset();
        run_vec(tbl[1]);
        set_req(0, 1'b1, 1'b0, 8'h01, 8'h01);
        last_grant = -1;
        for (int t = 0; t < 10 && last_grant != 0; t++) step();
        chk("rst_mid_grant0", last_grant, 0);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(2, 1'b1, 1'b0, 8'h20, 8'h02);
        set_req(3, 1'b1, 1'b0, 8'h30, 8'h03);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", rsp_valid, 0);
        chk("rst_async_result", rsp_result, 0);
        step();
        rst = 1'b0;
        step();
        chk("rst_first_grant", last_grant, 2);
        set_req(2, 1'b0, 1'b0, 8'h00, 8'h00);
        last_grant = -1;
        for (int t = 0; t < 10 && last_grant != 3; t++) step();
        chk("rst_second_grant", last_grant, 3);
        set_req(3, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (4) step();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (last_grant == i) req_valid[i] = 1'b0;
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(i, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
                end else if ($urandom_range(0, 49) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        clear_reqs();
        rsp_ready = 1'b1;
        repeat (4) step();

        // Two-requester build alternates grants.
        b_req_valid = 2'b11;
        b_req_op    = 2'b10;
        b_req_a     = {8'h03, 8'h0A};
        b_req_b     = {8'h0A, 8'h03};
        b_rsp_ready = 1'b1;
        ng2 = 0;
        nr2 = 0;
        for (int t = 0; t < 40 && nr2 < 4; t++) begin
            @(negedge clk);
            if (b_req_ready != 2'b00) begin
                chk("n2_grant", b_req_ready, 2'b01 << (ng2 % 2));
                ng2++;
            end
            if (b_rsp_valid && b_rsp_ready) begin
                chk("n2_id", b_rsp_id, nr2 % 2);
                chk("n2_result", b_rsp_result, (nr2 % 2) ? 8'hF9 : 8'h0D);
                chk("n2_flag", b_rsp_flag, nr2 % 2);
                nr2++;
            end
            @(posedge clk);
            #1;
        end
        chk("n2_count", nr2, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
